event_fifo: RTL

- Parametrised, lossy first-word-fall-through FIFO for address-event (x, y, polarity, timestamp) packets. It sits between the sensor event source and the downstream processing pipeline.
- Adds three things to a plain event queue: a valid/ready read handshake, a selectable overflow policy (drop-oldest or drop-newest), and occupancy and drop telemetry.
- The write side never stalls. The source has no back-pressure; events are lost only under the configured policy.

---
 rtl/event_pkg.sv | 18 +
 rtl/event_fifo_mem.sv | 25 ++
 rtl/event_fifo.sv | 114 +++++++++++
 3 files changed

// File: rtl/event_pkg.sv
// Shared definitions for address-event stream blocks: drop policies and field packing order.
// Every event-stream block packs fields {x, y, p, t}, MSB first.
package event_pkg;

    localparam int POLICY_DROP_NEWEST = 0;
    localparam int POLICY_DROP_OLDEST = 1;

    // Field order inside a packed event word, listed MSB first.
    typedef enum logic [1:0] {
        FIELD_X = 2'd0,
        FIELD_Y = 2'd1,
        FIELD_P = 2'd2,
        FIELD_T = 2'd3
    } event_field_e;

    localparam event_field_e EVENT_FIELD_ORDER [4] = '{FIELD_X, FIELD_Y, FIELD_P, FIELD_T};

endpackage

// File: rtl/event_fifo_mem.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
// Kept separate so a vendor RAM macro can replace it.
module event_fifo_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 97
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/event_fifo.sv
// Lossy first-word-fall-through event FIFO with drop-oldest/drop-newest overflow policy and telemetry.
// Push visible on out_* the next cycle; write side never stalls, full pushes drop per policy.
module event_fifo
    import event_pkg::*;
#(
    parameter int X_BITS      = 16,
    parameter int Y_BITS      = 16,
    parameter int T_BITS      = 64,
    parameter int DEPTH       = 64,
    parameter int DROP_OLDEST = 1,
    parameter int AFULL_LEVEL = DEPTH - 4,
    parameter int DROP_BITS   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [X_BITS-1:0]            in_x,
    input  logic [Y_BITS-1:0]            in_y,
    input  logic                         in_p,
    input  logic [T_BITS-1:0]            in_t,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [X_BITS-1:0]            out_x,
    output logic [Y_BITS-1:0]            out_y,
    output logic                         out_p,
    output logic [T_BITS-1:0]            out_t,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic [DROP_BITS-1:0]         drop_count,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);
    localparam bit OVERWRITE = (DROP_OLDEST == POLICY_DROP_OLDEST);

    typedef struct packed {
        logic [X_BITS-1:0] x;
        logic [Y_BITS-1:0] y;
        logic              p;
        logic [T_BITS-1:0] t;
    } event_t;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    event_t        wr_ev;
    event_t        rd_ev;
    logic          push;
    logic          pop;
    logic          full;
    logic          drop;
    logic          wr_en;
    logic          rd_adv;

    assign push  = in_valid;
    assign pop   = out_valid & out_ready;
    assign full  = (count == FULL_CNT);
    // Simultaneous push and pop on a full FIFO is a pass-through, not a drop.
    assign drop  = push & ~pop & full;
    assign wr_en = push & (~full | pop | OVERWRITE);
    assign rd_adv = pop | (drop & OVERWRITE);

    assign wr_ev = '{x: in_x, y: in_y, p: in_p, t: in_t};

    event_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(event_t))
    ) u_mem (
        .clk   (clk),
        .we    (wr_en & ~rst),
        .waddr (wr_ptr),
        .wdata (wr_ev),
        .raddr (rd_ptr),
        .rdata (rd_ev)
    );

    assign out_valid   = (count != '0);
    assign out_x       = rd_ev.x;
    assign out_y       = rd_ev.y;
    assign out_p       = rd_ev.p;
    assign out_t       = rd_ev.t;
    assign almost_full = (count >= AFULL_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop && !full) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

endmodule
